// File: rtl/riscv_div_seq_if.sv
// EX-stage <-> divider handshake: request/operands from EX, ready/valid/result back.
interface riscv_div_seq_if #(parameter int XLEN = 32);
  logic            div_en_i;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            kill_i;
  logic            ack_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output div_en_i, div_op_i, op_a_i, op_b_i, kill_i, ack_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  div_en_i, div_op_i, op_a_i, op_b_i, kill_i, ack_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/riscv_div_seq.sv
// Sequential RV32M DIV/DIVU/REM/REMU: radix-2 restoring division on magnitudes.
// States: IDLE wait | PREP take magnitudes | ITER one bit/cycle | FIX sign | DONE hold
module riscv_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  riscv_div_seq_if.slave  div_if
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q;
  logic            is_rem_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt_q;
  logic            ready_q;
  logic            valid_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            borrow;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quot_d;

  // Shifted remainder may reach XLEN+1 bits; if its top bit is set it always exceeds the divisor.
  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    trial   = {1'b0, shifted[XLEN-1:0]} - {1'b0, divisor_q};
    borrow  = ~shifted[XLEN] & trial[XLEN];
    rem_d   = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quot_d  = {quot_q[XLEN-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_rem_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      quot_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else if (div_if.kill_i && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_if.div_en_i && !div_if.kill_i) begin
            is_rem_q  <= div_if.div_op_i[1];
            sign_a_q  <= ~div_if.div_op_i[0] & div_if.op_a_i[XLEN-1];
            sign_b_q  <= ~div_if.div_op_i[0] & div_if.op_b_i[XLEN-1];
            quot_q    <= div_if.op_a_i;
            divisor_q <= div_if.op_b_i;
            ready_q   <= 1'b0;
            if (div_if.op_b_i == '0) begin
              result_q <= div_if.div_op_i[1] ? div_if.op_a_i : '1;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_PREP;
            end
          end
        end
        S_PREP: begin
          if (sign_a_q) quot_q <= -quot_q;
          if (sign_b_q) divisor_q <= -divisor_q;
          rem_q   <= '0;
          cnt_q   <= CW'(XLEN);
          state_q <= S_ITER;
        end
        S_ITER: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_rem_q) result_q <= sign_a_q ? -rem_q : rem_q;
          else          result_q <= (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (div_if.ack_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_if.ready_o  = ready_q;
  assign div_if.valid_o  = valid_q;
  assign div_if.result_o = result_q;

endmodule
